vga_frame_scanner: RTL
======================

# vga_frame_scanner

Downstream display stage of the vector processor: scans a 256x256 8-bit framebuffer in processor-visible RAM and drives a 640x480@60 Hz VGA DAC. The output fields are rgb, h_sync, v_sync and vga_clk. The block generates sync timing from a divide-by-2 pixel clock and fetches pixels through a 1-cycle-latency synchronous RAM read port. It converts each pixel to 24-bit RGB using per-channel intensity switches and a pixel-format switch, which are latched once per frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  in  1  system clock (2x pixel rate); one clock domain
- rst  in  1  reset, synchronous, active-high
- red_switches  in  2  red channel intensity select
- green_switches  in  2  green channel intensity select
- blue_switches  in  2  blue channel intensity select
- gtype_switch  in  1  pixel format: 0 = grayscale, 1 = RGB332
- mem_addr  out  16  framebuffer read address, {row[7:0], col[7:0]}
- mem_rdata  in  8  framebuffer read data, valid 1 clk after mem_addr
- rgb  out  24  {R[7:0], G[7:0], B[7:0]}
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- vga_clk  out  1  pixel clock to DAC, clk/2
- frame_start  out  1  1-clk pulse when the counters wrap to (0,0)

## Operation
- Phase bit ph toggles every clk and starts at 0 after reset. vga_clk = ph.
- Counters h_cnt (0..799) and v_cnt (0..524) advance on the edge where ph==1.
  - h_cnt wraps 799->0; v_cnt increments on h wrap and wraps 524->0.
- mem_addr is combinational: {v_cnt[7:0], h_cnt[7:0]}.
- Image window: h_cnt<256 && v_cnt<256. Everything else inside the active area is black.
- Output register, loaded on the ph==1 edge from the current (h_cnt, v_cnt) and mem_rdata:
  - h_sync = 0 iff 656 <= h_cnt <= 751.
  - v_sync = 0 iff 490 <= v_cnt <= 491.
  - rgb = 0 outside the active area (h_cnt>=640 or v_cnt>=480) and outside the image window.
  - rgb = converted pixel otherwise.
- Pixel conversion, gtype=0 (grayscale): base R = G = B = mem_rdata.
- Pixel conversion, gtype=1 (RGB332): d = mem_rdata.
  - R = {d[7:5], d[7:5], d[7:6]}
  - G = {d[4:2], d[4:2], d[4:3]}
  - B = {d[1:0], d[1:0], d[1:0], d[1:0]}
- Per-channel switch applied to the base value: 0 -> 0; 1 -> base>>2; 2 -> base>>1; 3 -> base.
- Switch latching: all four switch inputs are registered into shadow registers only on the clk where frame_start=1. Mid-frame switch changes take effect at the next frame.
- frame_start = 1 for the single clk following the ph==1 edge at which (h_cnt, v_cnt) becomes (0,0).

## Timing
- Reset values: ph=0, vga_clk=0, h_cnt=0, v_cnt=0, rgb=0, h_sync=1, v_sync=1, frame_start=0.
  - Shadow switches reset to red=3, green=3, blue=3, gtype=0.
- Reset asserted mid-frame: all of the above restored on the next edge; scanning restarts at (0,0) with ph=0.
- Reset does not produce a frame_start pulse. The first pulse occurs after one full frame: 800*525*2 = 840000 clk after reset release.
- Pixel period is 2 clk. The line is 1600 clk; the frame is 840000 clk.
- Pipeline: the rgb/sync outputs for pixel (h,v) appear one pixel period (2 clk) after the counters hold (h,v).
  - Syncs and rgb share this latency, so they stay mutually aligned.
- RAM contract: mem_addr is stable for 2 clk per pixel. mem_rdata is sampled on the second clk.
- Outputs change on ph 1->0 edges and are stable at each rising vga_clk.

## Test plan
- Reset: hold rst=1 for 5 clk -> rgb=0, h_sync=1, v_sync=1, vga_clk=0, frame_start=0. After release, vga_clk toggles every clk.
- Sync timing: run one frame.
  - h_sync low for exactly 96 pixels (192 clk) per line, first low pixel at h=656.
  - v_sync low for exactly 2 lines (3200 clk).
  - frame_start period 840000 clk.
- Grayscale fetch: RAM model with mem_rdata = addr[7:0], switches 3/3/3, gtype=0 -> pixel (h=10, v=3) gives rgb=24'h0A0A0A. Pixel (h=300, v=3) gives 0. Pixel (h=10, v=300) gives 0.
- Intensity switches: constant data 8'hFF, red=3, green=2, blue=1 latched at frame_start -> in-window rgb=24'hFF7F3F. red=0 -> R=0.
- RGB332: data 8'b101_010_01, all switches 3, gtype=1 -> rgb = {8'hB6, 8'h49, 8'h55}.
- Mid-frame switch change: set red 3->0 at v=100 -> rgb unchanged for the rest of the frame; R=0 from the first pixel after the next frame_start. Assert rst at v=200 -> counters return to 0 and outputs return to reset values the next clk.

Source files
------------

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: scans a 256x256 8-bit framebuffer and drives a VGA DAC.
// Sync timing runs at half the system clock. Pixels are fetched through a
// 1-cycle synchronous RAM port and converted to 24-bit RGB with per-channel
// intensity switches that are sampled once per frame.
module vga_frame_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_red_switches,
  input  logic [1:0]  i_green_switches,
  input  logic [1:0]  i_blue_switches,
  input  logic        i_gtype_switch,
  output logic [15:0] o_mem_addr,
  input  logic [7:0]  i_mem_rdata,
  output logic [23:0] o_rgb,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_vga_clk,
  output logic        o_frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        r_ph;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [23:0] r_rgb;
  logic        r_h_sync;
  logic        r_v_sync;
  logic        r_frame_start;
  logic [1:0]  r_red_sh;
  logic [1:0]  r_green_sh;
  logic [1:0]  r_blue_sh;
  logic        r_gtype_sh;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_in_active;
  logic        w_in_window;
  logic [7:0]  w_base_r;
  logic [7:0]  w_base_g;
  logic [7:0]  w_base_b;
  logic [23:0] w_pixel;

  // Intensity select: off, quarter, half or full brightness.
  function automatic logic [7:0] scale(input logic [7:0] base, input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'h00;
      2'd1:    return base >> 2;
      2'd2:    return base >> 1;
      default: return base;
    endcase
  endfunction

  assign w_h_wrap    = (r_h_cnt == H_LAST);
  assign w_v_wrap    = (r_v_cnt == V_LAST);
  assign w_in_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_in_window = (r_h_cnt < 10'd256) && (r_v_cnt < 10'd256);

  assign o_mem_addr    = {r_v_cnt[7:0], r_h_cnt[7:0]};
  assign o_rgb         = r_rgb;
  assign o_h_sync      = r_h_sync;
  assign o_v_sync      = r_v_sync;
  assign o_vga_clk     = r_ph;
  assign o_frame_start = r_frame_start;

  // Expand the fetched byte to base channel values, then apply the latched switches.
  always_comb begin
    w_base_r = i_mem_rdata;
    w_base_g = i_mem_rdata;
    w_base_b = i_mem_rdata;
    if (r_gtype_sh) begin
      w_base_r = {i_mem_rdata[7:5], i_mem_rdata[7:5], i_mem_rdata[7:6]};
      w_base_g = {i_mem_rdata[4:2], i_mem_rdata[4:2], i_mem_rdata[4:3]};
      w_base_b = {i_mem_rdata[1:0], i_mem_rdata[1:0], i_mem_rdata[1:0], i_mem_rdata[1:0]};
    end
    w_pixel = {scale(w_base_r, r_red_sh), scale(w_base_g, r_green_sh), scale(w_base_b, r_blue_sh)};
  end

  // Pixel phase, scan counters and the output register; all pixel work happens on ph==1,
  // which is the second clk of the pixel when the RAM data for the current address is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ph          <= 1'b0;
      r_h_cnt       <= 10'd0;
      r_v_cnt       <= 10'd0;
      r_rgb         <= 24'h0;
      r_h_sync      <= 1'b1;
      r_v_sync      <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_ph          <= ~r_ph;
      r_frame_start <= 1'b0;
      if (r_ph) begin
        if (w_h_wrap) begin
          r_h_cnt <= 10'd0;
          if (w_v_wrap) begin
            r_v_cnt       <= 10'd0;
            r_frame_start <= 1'b1;
          end else begin
            r_v_cnt <= r_v_cnt + 10'd1;
          end
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
        r_h_sync <= ~((r_h_cnt >= HS_START) && (r_h_cnt <= HS_END));
        r_v_sync <= ~((r_v_cnt >= VS_START) && (r_v_cnt <= VS_END));
        r_rgb    <= (w_in_active && w_in_window) ? w_pixel : 24'h0;
      end
    end
  end

  // Shadow the switches during the frame_start clk so a frame never changes colour mid-scan.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_red_sh   <= 2'd3;
      r_green_sh <= 2'd3;
      r_blue_sh  <= 2'd3;
      r_gtype_sh <= 1'b0;
    end else if (r_frame_start) begin
      r_red_sh   <= i_red_switches;
      r_green_sh <= i_green_switches;
      r_blue_sh  <= i_blue_switches;
      r_gtype_sh <= i_gtype_switch;
    end
  end

endmodule
